// File: rtl/inst_prefetch_buf.sv
// Instruction prefetch queue: runs sequential fetches ahead of the core over a
// single-outstanding req/ack memory port and buffers {pc, inst} pairs for fetch.
module inst_prefetch_buf #(
    parameter int                    DEPTH      = 4,
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    output logic                         mem_req_o,
    output logic [ADDR_WIDTH-1:0]        mem_addr_o,
    input  logic                         mem_ack_i,
    input  logic [DATA_WIDTH-1:0]        mem_data_i,
    input  logic                         redirect_i,
    input  logic [ADDR_WIDTH-1:0]        redirect_pc_i,
    output logic                         inst_valid_o,
    output logic [DATA_WIDTH-1:0]        inst_o,
    output logic [ADDR_WIDTH-1:0]        inst_pc_o,
    input  logic                         inst_ready_i,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t                 state_reg, state_next;
    logic [ADDR_WIDTH-1:0]  fetch_pc_reg, fetch_pc_next;
    logic [ADDR_WIDTH-1:0]  addr_reg, addr_next;
    logic [CNT_W-1:0]       count_reg, count_next;
    logic [PTR_W-1:0]       rd_ptr_reg, rd_ptr_next;
    logic [PTR_W-1:0]       wr_ptr_reg, wr_ptr_next;

    logic [ADDR_WIDTH-1:0]  pc_mem   [DEPTH];
    logic [DATA_WIDTH-1:0]  inst_mem [DEPTH];

    logic                   push, pop, room;
    logic [ADDR_WIDTH-1:0]  redirect_pc_aligned;
    logic [ADDR_WIDTH-1:0]  seq_pc;

    assign redirect_pc_aligned = redirect_pc_i & ~ADDR_WIDTH'(3);
    assign seq_pc              = addr_reg + ADDR_WIDTH'(4);

    // Redirect wins over both queue operations in the same cycle.
    assign inst_valid_o = (count_reg != '0);
    assign pop          = inst_valid_o & inst_ready_i & ~redirect_i;
    assign push         = (state_reg == REQ) & mem_ack_i & ~redirect_i;

    always_comb begin
        count_next  = count_reg;
        rd_ptr_next = rd_ptr_reg;
        wr_ptr_next = wr_ptr_reg;
        if (redirect_i) begin
            count_next  = '0;
            rd_ptr_next = '0;
            wr_ptr_next = '0;
        end else begin
            count_next  = count_reg + CNT_W'(push) - CNT_W'(pop);
            rd_ptr_next = rd_ptr_reg + PTR_W'(pop);
            wr_ptr_next = wr_ptr_reg + PTR_W'(push);
        end
    end

    // A new fetch is only launched when its data is guaranteed a free slot.
    assign room = (count_next < CNT_W'(DEPTH));

    always_comb begin
        state_next    = state_reg;
        fetch_pc_next = fetch_pc_reg;
        addr_next     = addr_reg;
        case (state_reg)
            IDLE: begin
                if (redirect_i) begin
                    state_next    = REQ;
                    fetch_pc_next = redirect_pc_aligned;
                    addr_next     = redirect_pc_aligned;
                end else if (room) begin
                    state_next = REQ;
                    addr_next  = fetch_pc_reg;
                end
            end
            REQ: begin
                if (redirect_i) begin
                    fetch_pc_next = redirect_pc_aligned;
                    if (mem_ack_i) begin
                        addr_next = redirect_pc_aligned;
                    end else begin
                        // Keep the stale request on the bus until memory accepts it.
                        state_next = DROP;
                    end
                end else if (mem_ack_i) begin
                    fetch_pc_next = seq_pc;
                    if (room) begin
                        addr_next = seq_pc;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            DROP: begin
                if (redirect_i) begin
                    fetch_pc_next = redirect_pc_aligned;
                    if (mem_ack_i) begin
                        state_next = REQ;
                        addr_next  = redirect_pc_aligned;
                    end
                end else if (mem_ack_i) begin
                    state_next = REQ;
                    addr_next  = fetch_pc_reg;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg    <= IDLE;
            fetch_pc_reg <= RESET_PC;
            addr_reg     <= '0;
            count_reg    <= '0;
            rd_ptr_reg   <= '0;
            wr_ptr_reg   <= '0;
        end else begin
            state_reg    <= state_next;
            fetch_pc_reg <= fetch_pc_next;
            addr_reg     <= addr_next;
            count_reg    <= count_next;
            rd_ptr_reg   <= rd_ptr_next;
            wr_ptr_reg   <= wr_ptr_next;
        end
    end

    // Storage carries no reset; the head outputs are masked while the queue is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr_reg]   <= addr_reg;
            inst_mem[wr_ptr_reg] <= mem_data_i;
        end
    end

    assign mem_req_o  = (state_reg != IDLE);
    assign mem_addr_o = addr_reg;
    assign inst_o     = inst_valid_o ? inst_mem[rd_ptr_reg] : '0;
    assign inst_pc_o  = inst_valid_o ? pc_mem[rd_ptr_reg]   : '0;
    assign count_o    = count_reg;

endmodule

// File: tb/tb_inst_prefetch_buf.sv
// Bench for inst_prefetch_buf: directed vector table, hand-written reset corner
// cases, then randomized traffic checked against a queue-based reference model.
module tb_inst_prefetch_buf;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_ack_i;
    logic [31:0] mem_data_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        inst_valid_o;
    logic [31:0] inst_o;
    logic [31:0] inst_pc_o;
    logic        inst_ready_i;
    logic [2:0]  count_o;

    always #5 clk = ~clk;

    inst_prefetch_buf #(
        .DEPTH(DEPTH), .ADDR_WIDTH(32), .DATA_WIDTH(32), .RESET_PC(RESET_PC)
    ) dut (
        .clk(clk), .rst(rst),
        .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o),
        .mem_ack_i(mem_ack_i), .mem_data_i(mem_data_i),
        .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
        .inst_valid_o(inst_valid_o), .inst_o(inst_o), .inst_pc_o(inst_pc_o),
        .inst_ready_i(inst_ready_i), .count_o(count_o)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model: a queue of buffered words plus the one outstanding fetch.
    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;
    ent_t        mq[$];
    bit          m_out;     // a fetch is on the bus
    bit          m_dead;    // that fetch's data must be thrown away
    logic [31:0] m_addr;
    logic [31:0] m_fpc;

    typedef struct {
        logic        ack;
        logic        redir;
        logic [31:0] rpc;
        logic        rdy;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_pc;
        logic [2:0]  e_cnt;
    } vec_t;
    vec_t vq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_step(input logic r, input logic a, input logic [31:0] d,
                              input logic rd, input logic [31:0] rp, input logic rdy);
        if (!r) begin
            mq.delete();
            m_out  = 1'b0;
            m_dead = 1'b0;
            m_addr = '0;
            m_fpc  = RESET_PC;
        end else if (rd) begin
            mq.delete();
            m_fpc = {rp[31:2], 2'b00};
            if (m_out && !a) begin
                m_dead = 1'b1;
            end else begin
                m_out  = 1'b1;
                m_dead = 1'b0;
                m_addr = m_fpc;
            end
        end else begin
            if (mq.size() != 0 && rdy) mq.delete(0);
            if (m_out && a) begin
                if (!m_dead) begin
                    mq.push_back('{pc: m_addr, inst: d});
                    m_fpc = m_addr + 32'd4;
                end
                m_out  = 1'b0;
                m_dead = 1'b0;
            end
            if (!m_out && mq.size() < DEPTH) begin
                m_out  = 1'b1;
                m_addr = m_fpc;
            end
        end
    endtask

    task automatic check_model(input string tag);
        logic [31:0] e_pc, e_inst;
        e_pc   = (mq.size() != 0) ? mq[0].pc   : 32'h0;
        e_inst = (mq.size() != 0) ? mq[0].inst : 32'h0;
        chk({tag, "_req"},   {31'b0, mem_req_o},    {31'b0, m_out});
        chk({tag, "_addr"},  mem_addr_o,            m_addr);
        chk({tag, "_valid"}, {31'b0, inst_valid_o}, {31'b0, mq.size() != 0});
        chk({tag, "_pc"},    inst_pc_o,             e_pc);
        chk({tag, "_inst"},  inst_o,                e_inst);
        chk({tag, "_count"}, {29'b0, count_o},      32'(mq.size()));
    endtask

    task automatic apply(input logic r, input logic a, input logic [31:0] d,
                         input logic rd, input logic [31:0] rp, input logic rdy);
        rst = r; mem_ack_i = a; mem_data_i = d;
        redirect_i = rd; redirect_pc_i = rp; inst_ready_i = rdy;
        $display("cyc %0d rst=%0b ack=%0b redir=%0b rpc=%h rdy=%0b | req=%0b addr=%h valid=%0b pc=%h cnt=%0d",
                 cyc, r, a, rd, rp, rdy, mem_req_o, mem_addr_o, inst_valid_o, inst_pc_o, count_o);
        model_step(r, a, d, rd, rp, rdy);
        cyc++;
    endtask

    task automatic add(input logic a, input logic rd, input logic [31:0] rp, input logic rdy,
                       input logic er, input logic [31:0] ea, input logic ev,
                       input logic [31:0] ep, input logic [2:0] ec);
        vq.push_back('{ack: a, redir: rd, rpc: rp, rdy: rdy, e_req: er, e_addr: ea,
                       e_valid: ev, e_pc: ep, e_cnt: ec});
    endtask

    initial begin
        // Each row: inputs for this cycle | outputs expected before its edge.
        add(0, 0, 32'h0,         1,  0, 32'h00,        0, 32'h0,         0);
        add(1, 0, 32'h0,         1,  1, 32'h00,        0, 32'h0,         0);
        add(1, 0, 32'h0,         1,  1, 32'h04,        1, 32'h0,         1);
        add(1, 0, 32'h0,         1,  1, 32'h08,        1, 32'h4,         1);
        add(1, 0, 32'h0,         0,  1, 32'h0C,        1, 32'h8,         1);
        add(1, 0, 32'h0,         0,  1, 32'h10,        1, 32'h8,         2);
        add(1, 0, 32'h0,         0,  1, 32'h14,        1, 32'h8,         3);
        add(1, 0, 32'h0,         0,  0, 32'h14,        1, 32'h8,         4);
        add(0, 0, 32'h0,         1,  0, 32'h14,        1, 32'h8,         4);
        add(0, 0, 32'h0,         0,  1, 32'h18,        1, 32'hC,         3);
        add(0, 1, 32'h100,       1,  1, 32'h18,        1, 32'hC,         3);
        add(0, 0, 32'h0,         1,  1, 32'h18,        0, 32'h0,         0);
        add(1, 0, 32'h0,         1,  1, 32'h18,        0, 32'h0,         0);
        add(1, 0, 32'h0,         1,  1, 32'h100,       0, 32'h0,         0);
        add(1, 1, 32'h200,       1,  1, 32'h104,       1, 32'h100,       1);
        add(0, 0, 32'h0,         1,  1, 32'h200,       0, 32'h0,         0);
        add(1, 1, 32'h103,       1,  1, 32'h200,       0, 32'h0,         0);
        add(1, 0, 32'h0,         1,  1, 32'h100,       0, 32'h0,         0);
        add(1, 1, 32'hFFFF_FFFC, 0,  1, 32'h104,       1, 32'h100,       1);
        add(1, 0, 32'h0,         0,  1, 32'hFFFF_FFFC, 0, 32'h0,         0);
        add(1, 0, 32'h0,         0,  1, 32'h0,         1, 32'hFFFF_FFFC, 1);
        add(0, 0, 32'h0,         1,  1, 32'h4,         1, 32'hFFFF_FFFC, 2);
        add(0, 0, 32'h0,         0,  1, 32'h4,         1, 32'h0,         1);

        // Reset
        rst = 1'b0; mem_ack_i = 1'b0; mem_data_i = '0;
        redirect_i = 1'b0; redirect_pc_i = '0; inst_ready_i = 1'b0;
        model_step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req",   {31'b0, mem_req_o},    32'h0);
        chk("rst_addr",  mem_addr_o,            32'h0);
        chk("rst_valid", {31'b0, inst_valid_o}, 32'h0);
        chk("rst_inst",  inst_o,                32'h0);
        chk("rst_pc",    inst_pc_o,             32'h0);
        chk("rst_count", {29'b0, count_o},      32'h0);

        // Directed vector table
        for (int i = 0; i < vq.size(); i++) begin
            if (i != 0) @(negedge clk);
            chk($sformatf("tbl%0d_req", i),   {31'b0, mem_req_o},    {31'b0, vq[i].e_req});
            chk($sformatf("tbl%0d_addr", i),  mem_addr_o,            vq[i].e_addr);
            chk($sformatf("tbl%0d_valid", i), {31'b0, inst_valid_o}, {31'b0, vq[i].e_valid});
            chk($sformatf("tbl%0d_pc", i),    inst_pc_o,             vq[i].e_pc);
            chk($sformatf("tbl%0d_count", i), {29'b0, count_o},      {29'b0, vq[i].e_cnt});
            check_model("tblm");
            apply(1'b1, vq[i].ack, 32'hC0DE_0000 + 32'(i), vq[i].redir, vq[i].rpc, vq[i].rdy);
        end

        // Reset with a partly filled queue, then reset while dropping a fetch
        @(negedge clk); check_model("t6a");
        apply(1'b1, 1'b1, 32'hAAAA_0001, 1'b0, 32'h0, 1'b0);
        @(negedge clk); check_model("t6b");
        apply(1'b1, 1'b1, 32'hAAAA_0002, 1'b0, 32'h0, 1'b0);
        @(negedge clk); check_model("t6c");
        chk("t6_count3", {29'b0, count_o}, 32'd3);
        apply(1'b0, 1'b1, 32'hAAAA_0003, 1'b0, 32'h0, 1'b1);
        @(negedge clk); check_model("t6d");
        chk("t6_req_off",  {31'b0, mem_req_o},    32'h0);
        chk("t6_valid0",   {31'b0, inst_valid_o}, 32'h0);
        chk("t6_count0",   {29'b0, count_o},      32'h0);
        apply(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        @(negedge clk); check_model("t6e");
        chk("t6_req_on",   {31'b0, mem_req_o}, 32'h1);
        chk("t6_addr_rpc", mem_addr_o,         RESET_PC);
        apply(1'b1, 1'b0, 32'h0, 1'b1, 32'h40, 1'b1);
        @(negedge clk); check_model("t6f");
        chk("t6_drop_addr", mem_addr_o, RESET_PC);
        apply(1'b0, 1'b1, 32'h0, 1'b1, 32'h80, 1'b1);
        @(negedge clk); check_model("t6g");
        chk("t6_drop_rst_req", {31'b0, mem_req_o}, 32'h0);
        apply(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        @(negedge clk); check_model("t6h");
        chk("t6_restart_addr", mem_addr_o, RESET_PC);

        // Randomized traffic against the model
        for (int n = 0; n < 1500; n++) begin
            logic        r_rst, r_ack, r_red, r_rdy;
            logic [31:0] r_pc;
            if (n != 0) begin
                @(negedge clk);
                check_model("rnd");
            end
            r_rst = ($urandom_range(0, 99) != 0);
            r_ack = ($urandom_range(0, 9) < 6);
            r_red = ($urandom_range(0, 19) == 0);
            r_rdy = ($urandom_range(0, 9) < 6);
            r_pc  = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                : $urandom;
            apply(r_rst, r_ack, $urandom, r_red, r_pc, r_rdy);
        end
        @(negedge clk);
        check_model("end");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
